reservation_station_param: RTL and testbench
============================================

Name: reservation_station_param

Overview:
- Parametrised, unified reservation station that replaces the fixed 4-entry add/multiply/divide stations.
- Sits between rename/dispatch and one functional unit.
- Holds renamed micro-ops until both source physical registers are valid. Wakeup comes from NUM_CDB broadcast ports.
- Issues the oldest ready entry to the functional unit through a valid/ready handshake. Supports full flush on mispredict.

Parameters:
- DEPTH, 4: number of entries (power of two, 2..16).
- PREG_W, 6: physical register tag width.
- AREG_W, 5: architectural register index width.
- ROB_W, 6: ROB index width.
- NUM_CDB, 2: number of CDB wakeup ports (1..4).
- PAYLOAD_W, 64: opaque decode payload width (funct3/funct7/opcode/imm subset), carried unmodified.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; kills all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_ps1  in  PREG_W  source 1 tag
- disp_ps1_v  in  1  source 1 already valid
- disp_ps2  in  PREG_W  source 2 tag
- disp_ps2_v  in  1  source 2 already valid
- disp_pd  in  PREG_W  destination tag
- disp_rd  in  AREG_W  architectural destination
- disp_rob  in  ROB_W  ROB index
- disp_payload  in  PAYLOAD_W  decode payload
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_pd  in  NUM_CDB*PREG_W  per-port broadcast tags, port k at [k*PREG_W +: PREG_W]
- iss_valid  out  1  an entry is selected for issue
- iss_ready  in  1  functional unit accepts
- iss_ps1, iss_ps2, iss_pd  out  PREG_W each  issued tags
- iss_rd  out  AREG_W
- iss_rob  out  ROB_W
- iss_payload  out  PAYLOAD_W
- occupancy  out  $clog2(DEPTH)+1  number of busy entries

Behaviour:
- Reset (rst_n low, async): all busy=0, age matrix=0, occupancy=0, iss_valid=0, disp_ready=1. Issue data outputs are 0 when iss_valid=0.
- Entry state: busy, ps1/ps1_v, ps2/ps2_v, pd, rd, rob, payload. Age matrix bit [i][j]=1 means entry i is older than j.
- Dispatch:
  - Accepted at posedge when disp_valid && disp_ready && !flush.
  - Writes the lowest-index free entry and sets it older-than-none: row cleared, column set for every busy entry.
- disp_ready: combinational from registered busy only. It is 0 when all DEPTH entries are busy, even if an issue fires the same cycle (no same-cycle slot reuse).
- Wakeup: for each busy entry and each port k with cdb_valid[k] and cdb_pd[k]==ps1 (or ps2), set ps1_v (or ps2_v) at posedge.
  - Several ports matching the same tag is legal.
- Dispatch/wakeup collision: if a dispatching operand tag matches any valid CDB port in the same cycle, the stored _v is 1 regardless of disp_psX_v.
- Ready: busy && ps1_v && ps2_v (registered state; see optional feature).
- Select: the oldest ready entry, i.e. no other ready entry is older. iss_valid and iss_* are combinational from state.
- Issue handshake: iss_valid && iss_ready at posedge frees the selected entry (busy=0) and clears its age column. Outputs are held stable while iss_valid && !iss_ready, unless an older entry becomes ready.
- Simultaneous dispatch and issue: both take effect. occupancy stays unchanged and the new entry is younger than all survivors.
- Flush:
  - At posedge, all busy=0 and occupancy=0; dispatch that cycle is dropped.
  - iss_valid is forced 0 combinationally while flush=1.
  - Flush has priority over every other event.
- occupancy: registered, +1 on accepted dispatch, -1 on issue, net 0 on both. It never exceeds DEPTH or goes below 0.
- Reset mid-operation: immediate clear, no pending issue survives.

Optional Feature:
- Macro RS_WAKEUP_BYPASS_EN.
- When defined: an entry whose last missing operand matches a valid CDB port this cycle is ready combinationally and may issue the same cycle (zero-cycle wakeup-to-issue). The bypassed iss_valid still obeys flush gating.
- When undefined: such an entry becomes ready only from the next cycle (one-cycle wakeup-to-issue latency).

Test Plan:
- Reset, then dispatch 4 ops with both _v=1 and iss_ready=1 -> issued in dispatch order on 4 consecutive cycles starting 1 cycle after first dispatch; occupancy 0,1,1,1,1,0 pattern.
- Fill DEPTH=4 with ps1=6'd10 not valid -> disp_ready=0, iss_valid=0. Then cdb_valid[1]=1 with cdb_pd port1=10 -> without macro iss_valid=1 next cycle, oldest (first dispatched rob) first. With macro iss_valid=1 in the broadcast cycle.
- Dispatch with ps2=6'd7, ps2_v=0 while cdb port0 broadcasts 7 the same cycle -> entry stored ready; issues next cycle.
- Hold iss_ready=0 with 2 ready entries for 5 cycles -> iss_rob stable at the older entry; occupancy=2; releasing iss_ready frees entries in age order.
- Full station, iss_ready=1, disp_valid=1 -> dispatch refused this cycle (disp_ready=0); occupancy 4->3, then accepted next cycle.
- 3 busy entries, flush=1 with disp_valid=1 -> iss_valid=0 during flush, occupancy=0 next cycle, dispatched op absent; async rst_n pulse mid-issue gives the same empty state.

Source files
------------

// File: rtl/reservation_station_param.sv
// reservation_station_param: unified reservation station feeding one functional unit.
// Holds renamed micro-ops until both source tags are valid (woken by NUM_CDB
// broadcast ports) and issues the oldest ready entry over a valid/ready handshake.
// Optional feature macro: RS_WAKEUP_BYPASS_EN (zero-cycle wakeup-to-issue).
module reservation_station_param #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned AREG_W    = 5,
    parameter int unsigned ROB_W     = 6,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned PAYLOAD_W = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [PREG_W-1:0]           disp_ps1,
    input  logic                        disp_ps1_v,
    input  logic [PREG_W-1:0]           disp_ps2,
    input  logic                        disp_ps2_v,
    input  logic [PREG_W-1:0]           disp_pd,
    input  logic [AREG_W-1:0]           disp_rd,
    input  logic [ROB_W-1:0]            disp_rob,
    input  logic [PAYLOAD_W-1:0]        disp_payload,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*PREG_W-1:0]   cdb_pd,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [PREG_W-1:0]           iss_ps1,
    output logic [PREG_W-1:0]           iss_ps2,
    output logic [PREG_W-1:0]           iss_pd,
    output logic [AREG_W-1:0]           iss_rd,
    output logic [ROB_W-1:0]            iss_rob,
    output logic [PAYLOAD_W-1:0]        iss_payload,
    output logic [$clog2(DEPTH):0]      occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    // Entry control state
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     ps1_v;
    logic [DEPTH-1:0]     ps2_v;
    // age[i][j] = 1 : entry i is older than entry j
    logic [DEPTH-1:0]     age [DEPTH];
    logic [OCC_W-1:0]     occ_q;

    // Entry data state
    logic [PREG_W-1:0]    ps1     [DEPTH];
    logic [PREG_W-1:0]    ps2     [DEPTH];
    logic [PREG_W-1:0]    pd      [DEPTH];
    logic [AREG_W-1:0]    rd      [DEPTH];
    logic [ROB_W-1:0]     rob     [DEPTH];
    logic [PAYLOAD_W-1:0] payload [DEPTH];

    // Combinational helpers
    logic [DEPTH-1:0]     wake1;
    logic [DEPTH-1:0]     wake2;
    logic [DEPTH-1:0]     ready;
    logic [DEPTH-1:0]     sel_oh;
    logic [DEPTH-1:0]     free_oh;
    logic                 free_found;
    logic                 disp_hit1;
    logic                 disp_hit2;
    logic                 disp_fire;
    logic                 iss_fire;

    // True when any valid CDB port broadcasts the given tag
    function automatic logic cdb_hit(
        input logic [PREG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]        v,
        input logic [NUM_CDB*PREG_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (v[k] && (tags[k*PREG_W +: PREG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign disp_hit1  = cdb_hit(disp_ps1, cdb_valid, cdb_pd);
    assign disp_hit2  = cdb_hit(disp_ps2, cdb_valid, cdb_pd);
    assign disp_ready = ~&busy;
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign iss_fire   = iss_valid && iss_ready;
    assign occupancy  = occ_q;

    // Per-entry wakeup match against this cycle's CDB broadcasts
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wake1[i] = cdb_hit(ps1[i], cdb_valid, cdb_pd);
            wake2[i] = cdb_hit(ps2[i], cdb_valid, cdb_pd);
        end
    end

    // Ready vector: registered operand state, optionally bypassed with live wakeups
    always_comb begin
        ready = '0;
`ifdef RS_WAKEUP_BYPASS_EN
        ready = busy & (ps1_v | wake1) & (ps2_v | wake2);
`else
        ready = busy & ps1_v & ps2_v;
`endif
    end

    // Oldest-ready select: an entry wins if no other ready entry is older
    always_comb begin
        sel_oh = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_oh[i] = ready[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((j != i) && ready[j] && age[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
    end

    assign iss_valid = (|sel_oh) && !flush;

    // Issue data mux; all zero whenever nothing is being presented
    always_comb begin
        iss_ps1     = '0;
        iss_ps2     = '0;
        iss_pd      = '0;
        iss_rd      = '0;
        iss_rob     = '0;
        iss_payload = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel_oh[i] && iss_valid) begin
                iss_ps1     = iss_ps1     | ps1[i];
                iss_ps2     = iss_ps2     | ps2[i];
                iss_pd      = iss_pd      | pd[i];
                iss_rd      = iss_rd      | rd[i];
                iss_rob     = iss_rob     | rob[i];
                iss_payload = iss_payload | payload[i];
            end
        end
    end

    // Lowest-index free entry for dispatch
    always_comb begin
        free_oh    = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    // Control state: busy, operand valids, age matrix and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            ps1_v <= '0;
            ps2_v <= '0;
            occ_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else if (flush) begin
            busy  <= '0;
            occ_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (busy[i] && wake1[i]) ps1_v[i] <= 1'b1;
                if (busy[i] && wake2[i]) ps2_v[i] <= 1'b1;
                if (iss_fire && sel_oh[i]) busy[i] <= 1'b0;
                if (disp_fire && free_oh[i]) begin
                    busy[i]  <= 1'b1;
                    ps1_v[i] <= disp_ps1_v | disp_hit1;
                    ps2_v[i] <= disp_ps2_v | disp_hit2;
                    age[i]   <= '0;
                end
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    // Issued entry's column clears; new entry's column marks every survivor older
                    if (iss_fire && sel_oh[j]) begin
                        age[i][j] <= 1'b0;
                    end
                    if (disp_fire && free_oh[j] && (i != j)) begin
                        age[i][j] <= busy[i] && !(iss_fire && sel_oh[i]);
                    end
                end
            end
            case ({disp_fire, iss_fire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Entry payload storage, written on dispatch only
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (disp_fire && free_oh[i]) begin
                ps1[i]     <= disp_ps1;
                ps2[i]     <= disp_ps2;
                pd[i]      <= disp_pd;
                rd[i]      <= disp_rd;
                rob[i]     <= disp_rob;
                payload[i] <= disp_payload;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station_param.sv
// Scoreboard bench for reservation_station_param (default parameters).
module tb_reservation_station_param;

    typedef struct packed {
        logic [5:0]  ps1;
        logic [5:0]  ps2;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [5:0]  rob;
        logic [63:0] payload;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [5:0]  disp_ps1;
    logic        disp_ps1_v;
    logic [5:0]  disp_ps2;
    logic        disp_ps2_v;
    logic [5:0]  disp_pd;
    logic [4:0]  disp_rd;
    logic [5:0]  disp_rob;
    logic [63:0] disp_payload;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_pd;
    logic        iss_valid;
    logic        iss_ready;
    logic [5:0]  iss_ps1;
    logic [5:0]  iss_ps2;
    logic [5:0]  iss_pd;
    logic [4:0]  iss_rd;
    logic [5:0]  iss_rob;
    logic [63:0] iss_payload;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;
    op_t exp_q[$];

    reservation_station_param #(
        .DEPTH(4), .PREG_W(6), .AREG_W(5), .ROB_W(6), .NUM_CDB(2), .PAYLOAD_W(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ps1(disp_ps1), .disp_ps1_v(disp_ps1_v),
        .disp_ps2(disp_ps2), .disp_ps2_v(disp_ps2_v),
        .disp_pd(disp_pd), .disp_rd(disp_rd), .disp_rob(disp_rob),
        .disp_payload(disp_payload),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd),
        .iss_rd(iss_rd), .iss_rob(iss_rob), .iss_payload(iss_payload),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic [5:0] r, input logic [5:0] p1);
        op_t o;
        o.ps1     = p1;
        o.ps2     = r + 6'd32;
        o.pd      = r + 6'd16;
        o.rd      = r[4:0];
        o.rob     = r;
        o.payload = {32'hC0DE_0000, 26'd0, r};
        return o;
    endfunction

    task automatic drive(input op_t o, input logic v1, input logic v2, input bit push);
        disp_valid   = 1'b1;
        disp_ps1     = o.ps1;
        disp_ps1_v   = v1;
        disp_ps2     = o.ps2;
        disp_ps2_v   = v2;
        disp_pd      = o.pd;
        disp_rd      = o.rd;
        disp_rob     = o.rob;
        disp_payload = o.payload;
        if (push) exp_q.push_back(o);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Monitor: every accepted issue must match the next expected op
    always @(negedge clk) begin
        if (rst_n && iss_valid && iss_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual rob=%0h expected=none", iss_rob);
            end else begin
                op_t e;
                op_t got;
                e   = exp_q.pop_front();
                got = {iss_ps1, iss_ps2, iss_pd, iss_rd, iss_rob, iss_payload};
                chk("issue_rob", 128'(iss_rob), 128'(e.rob));
                chk("issue_fields", 128'(got), 128'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp_ps1 = '0; disp_ps1_v = 1'b0; disp_ps2 = '0; disp_ps2_v = 1'b0;
        disp_pd = '0; disp_rd = '0; disp_rob = '0; disp_payload = '0;
        cdb_valid = '0; cdb_pd = '0; iss_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_occ", 128'(occupancy), 128'(0));
        chk("reset_disp_ready", 128'(disp_ready), 128'(1));
        chk("reset_iss_valid", 128'(iss_valid), 128'(0));
        chk("reset_iss_payload", 128'(iss_payload), 128'(0));
        rst_n = 1'b1;
        next();

        // 1: four ready ops stream through in dispatch order, occupancy 0,1,1,1,1,0
        iss_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive(mk(6'(1 + n), 6'd60), 1'b1, 1'b1, 1'b1);
            half();
            chk("t1_occ", 128'(occupancy), 128'(n == 0 ? 0 : 1));
            chk("t1_iss_valid", 128'(iss_valid), 128'(n == 0 ? 0 : 1));
            next();
        end
        disp_valid = 1'b0;
        half();
        chk("t1_occ_last", 128'(occupancy), 128'(1));
        next();
        half();
        chk("t1_occ_end", 128'(occupancy), 128'(0));
        chk("t1_iss_valid_end", 128'(iss_valid), 128'(0));
        next();

        // 2: fill with ps1=10 pending, wake via CDB port 1
        for (int n = 0; n < 4; n++) begin
            drive(mk(6'(10 + n), 6'd10), 1'b0, 1'b1, 1'b1);
            half();
            chk("t2_iss_valid_fill", 128'(iss_valid), 128'(0));
            next();
        end
        disp_valid = 1'b0;
        half();
        chk("t2_occ_full", 128'(occupancy), 128'(4));
        chk("t2_disp_ready_full", 128'(disp_ready), 128'(0));
        chk("t2_iss_valid_full", 128'(iss_valid), 128'(0));
        next();
        cdb_valid = 2'b10;
        cdb_pd    = {6'd10, 6'd0};
        half();
`ifdef RS_WAKEUP_BYPASS_EN
        chk("t2_iss_valid_bcast", 128'(iss_valid), 128'(1));
`else
        chk("t2_iss_valid_bcast", 128'(iss_valid), 128'(0));
`endif
        next();
        cdb_valid = '0;
        cdb_pd    = '0;
        half();
        chk("t2_iss_valid_after", 128'(iss_valid), 128'(1));
        repeat (4) next();
        half();
        chk("t2_occ_end", 128'(occupancy), 128'(0));
        next();

        // 3: dispatch collides with same-cycle broadcast of its ps2 tag
        begin
            op_t o;
            o = mk(6'd5, 6'd60);
            o.ps2 = 6'd7;
            drive(o, 1'b1, 1'b0, 1'b1);
        end
        cdb_valid = 2'b01;
        cdb_pd    = {6'd0, 6'd7};
        next();
        disp_valid = 1'b0;
        cdb_valid  = '0;
        cdb_pd     = '0;
        half();
        chk("t3_iss_valid", 128'(iss_valid), 128'(1));
        chk("t3_occ", 128'(occupancy), 128'(1));
        next();
        half();
        chk("t3_occ_end", 128'(occupancy), 128'(0));
        next();

        // 4: stall with two ready entries, outputs hold on the older one
        iss_ready = 1'b0;
        drive(mk(6'd20, 6'd60), 1'b1, 1'b1, 1'b1);
        next();
        drive(mk(6'd21, 6'd60), 1'b1, 1'b1, 1'b1);
        next();
        disp_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            half();
            chk("t4_hold_rob", 128'(iss_rob), 128'(20));
            chk("t4_hold_occ", 128'(occupancy), 128'(2));
            next();
        end
        iss_ready = 1'b1;
        next();
        next();
        half();
        chk("t4_occ_end", 128'(occupancy), 128'(0));
        next();

        // 5: full station refuses dispatch in the cycle an issue frees a slot
        iss_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            drive(mk(6'(30 + n), 6'd60), 1'b1, 1'b1, 1'b1);
            next();
        end
        drive(mk(6'd34, 6'd60), 1'b1, 1'b1, 1'b1);
        iss_ready = 1'b1;
        half();
        chk("t5_disp_ready_full", 128'(disp_ready), 128'(0));
        chk("t5_occ_full", 128'(occupancy), 128'(4));
        next();
        half();
        chk("t5_occ_after_refuse", 128'(occupancy), 128'(3));
        chk("t5_disp_ready_free", 128'(disp_ready), 128'(1));
        next();
        disp_valid = 1'b0;
        half();
        chk("t5_occ_after_accept", 128'(occupancy), 128'(3));
        repeat (3) next();
        half();
        chk("t5_occ_end", 128'(occupancy), 128'(0));
        next();

        // 6a: flush with three entries and a dispatch in the same cycle
        iss_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(mk(6'(40 + n), 6'd60), 1'b1, 1'b1, 1'b0);
            next();
        end
        drive(mk(6'd43, 6'd60), 1'b1, 1'b1, 1'b0);
        flush     = 1'b1;
        iss_ready = 1'b1;
        half();
        chk("t6_iss_valid_flush", 128'(iss_valid), 128'(0));
        next();
        flush      = 1'b0;
        disp_valid = 1'b0;
        half();
        chk("t6_occ_flushed", 128'(occupancy), 128'(0));
        chk("t6_disp_ready_flushed", 128'(disp_ready), 128'(1));
        chk("t6_iss_valid_flushed", 128'(iss_valid), 128'(0));
        next();
        half();
        chk("t6_dropped_absent", 128'(iss_valid), 128'(0));
        next();

        // 6b: asynchronous reset pulse while an issue handshake is pending
        iss_ready = 1'b0;
        drive(mk(6'd50, 6'd60), 1'b1, 1'b1, 1'b0);
        next();
        drive(mk(6'd51, 6'd60), 1'b1, 1'b1, 1'b0);
        next();
        disp_valid = 1'b0;
        half();
        chk("t6_pre_reset_occ", 128'(occupancy), 128'(2));
        chk("t6_pre_reset_valid", 128'(iss_valid), 128'(1));
        #1 iss_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_occ", 128'(occupancy), 128'(0));
        chk("t6_rst_iss_valid", 128'(iss_valid), 128'(0));
        chk("t6_rst_disp_ready", 128'(disp_ready), 128'(1));
        chk("t6_rst_iss_rob", 128'(iss_rob), 128'(0));
        #1 rst_n = 1'b1;
        next();
        half();
        chk("t6_post_reset_valid", 128'(iss_valid), 128'(0));
        chk("t6_post_reset_occ", 128'(occupancy), 128'(0));
        next();

        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
